// File: rtl/spike_threshold_scheduler.sv
// Scans NUM_NEURONS membrane potentials through one shared FP comparator,
// flags spikes and writes the reset potential back for neurons that fired.
module spike_threshold_scheduler #(
  parameter int NUM_NEURONS = 16,
  parameter int ADDR_W      = 4,
  parameter int CNT_W       = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            threshold,
  input  logic [31:0]            v_reset,
  output logic                   mem_rd_en,
  output logic                   mem_wr_en,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [31:0]            mem_wr_data,
  input  logic [31:0]            mem_rd_data,
  output logic [31:0]            cmp_a,
  output logic [31:0]            cmp_b,
  input  logic                   cmp_lt,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_NEURONS-1:0] spike_vec,
  output logic [CNT_W-1:0]       spike_count
);

  // state | meaning
  // IDLE  | waiting for start; latches threshold/v_reset on acceptance
  // READ  | read strobe for neuron idx is on the RAM port
  // CMP   | read data valid, spike decision captured
  // WB    | reset-potential write (if fired), advance or finish
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {IDLE, READ, CMP, WB, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  state_t            state;
  logic [31:0]       thr_q;
  logic [31:0]       vr_q;
  logic [ADDR_W-1:0] idx;
  logic              fire;

  assign cmp_a = mem_rd_data;
  assign cmp_b = thr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      thr_q       <= '0;
      vr_q        <= '0;
      idx         <= '0;
      fire        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      spike_vec   <= '0;
      spike_count <= '0;
    end else begin
      // strobes and their address/data are pulses; each state re-asserts what it needs
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            thr_q       <= threshold;
            vr_q        <= v_reset;
            spike_vec   <= '0;
            spike_count <= '0;
            idx         <= '0;
            busy        <= 1'b1;
            mem_rd_en   <= 1'b1;
            mem_addr    <= '0;
            state       <= READ;
          end
        end
        READ: state <= CMP;
        CMP: begin
          fire <= ~cmp_lt;
          if (!cmp_lt) begin
            mem_wr_en   <= 1'b1;
            mem_addr    <= idx;
            mem_wr_data <= vr_q;
          end
          state <= WB;
        end
        WB: begin
          if (fire) begin
            spike_vec[idx] <= 1'b1;
            spike_count    <= spike_count + CNT_W'(1);
          end
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx       <= idx + ADDR_W'(1);
            mem_rd_en <= 1'b1;
            mem_addr  <= idx + ADDR_W'(1);
            state     <= READ;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_threshold_scheduler.sv
// Bench for spike_threshold_scheduler: RAM and comparator models plus a
// write scoreboard filled from a reference model of each pass.
module tb_spike_threshold_scheduler;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   threshold = '0;
  logic [31:0]   v_reset = '0;
  logic          mem_rd_en, mem_wr_en;
  logic [3:0]    mem_addr;
  logic [31:0]   mem_wr_data;
  logic [31:0]   mem_rd_data = '0;
  logic [31:0]   cmp_a, cmp_b;
  logic          cmp_lt;
  logic          busy, done;
  logic [N-1:0]  spike_vec;
  logic [4:0]    spike_count;

  logic [31:0]   ram     [0:N-1];
  logic [31:0]   exp_mem [0:N-1];
  logic [35:0]   wq [$];
  logic [N-1:0]  exp_vec;
  int            exp_cnt;
  int            rd_idx = 0;
  int            checks = 0;
  int            errors = 0;

  spike_threshold_scheduler #(.NUM_NEURONS(N), .ADDR_W(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .threshold(threshold), .v_reset(v_reset),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_lt(cmp_lt),
    .busy(busy), .done(done), .spike_vec(spike_vec), .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  // sign of (a - b) for ordinary IEEE singles; +0 and -0 compare equal
  function automatic logic fp_lt(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction

  assign cmp_lt = fp_lt(cmp_a, cmp_b);

  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] = mem_wr_data;
    if (mem_rd_en) mem_rd_data <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // write scoreboard and read-address sequence
  always @(negedge clk) begin
    if (mem_rd_en) begin
      chk("rd_addr", 64'(mem_addr), 64'(rd_idx));
      chk("rd_wr_same_cycle", 64'(mem_wr_en), 64'(0));
      rd_idx++;
    end
    if (mem_wr_en) begin
      chk("wr_expected", 64'(wq.size() != 0), 64'(1));
      if (wq.size() != 0) begin
        logic [35:0] e;
        e = wq.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e[35:32]));
        chk("wr_data", 64'(mem_wr_data), 64'(e[31:0]));
      end
    end
  end

  task automatic set_mem(input int i, input logic [31:0] v);
    ram[i] = v;
    exp_mem[i] = v;
  endtask

  task automatic fill_mem(input logic [31:0] v);
    for (int i = 0; i < N; i++) set_mem(i, v);
  endtask

  task automatic plan_pass(input logic [31:0] thr, input logic [31:0] vr);
    exp_vec = '0;
    exp_cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (!fp_lt(exp_mem[i], thr)) begin
        wq.push_back({4'(i), vr});
        exp_vec[i] = 1'b1;
        exp_cnt++;
        exp_mem[i] = vr;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one full pass; cycle c is the c-th clock period after the accepting edge
  task automatic do_pass(input logic [31:0] thr, input logic [31:0] vr, input bit repulse);
    plan_pass(thr, vr);
    @(negedge clk);
    threshold = thr;
    v_reset   = vr;
    start     = 1'b1;
    rd_idx    = 0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 49; c++) begin
      @(negedge clk);
      if (repulse) begin
        start = (c == 5 || c == 20 || c == 49);
        if (c == 10) begin
          threshold = 32'hC000_0000;
          v_reset   = 32'h1234_5678;
        end
      end
      chk("busy", 64'(busy), 64'(c <= 48));
      chk("done", 64'(done), 64'(c == 49));
      if (c == 1) begin
        chk("spike_vec_cleared", 64'(spike_vec), 64'(0));
        chk("spike_count_cleared", 64'(spike_count), 64'(0));
      end
    end
    chk("spike_vec", 64'(spike_vec), 64'(exp_vec));
    chk("spike_count", 64'(spike_count), 64'(exp_cnt));
    chk("writes_drained", 64'(wq.size()), 64'(0));
    if (repulse) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  initial begin
    fill_mem(32'h3F00_0000);

    // reset state
    idle(3);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_rd_en", 64'(mem_rd_en), 64'(0));
    chk("rst_wr_en", 64'(mem_wr_en), 64'(0));
    chk("rst_addr", 64'(mem_addr), 64'(0));
    chk("rst_wr_data", 64'(mem_wr_data), 64'(0));
    chk("rst_spike_vec", 64'(spike_vec), 64'(0));
    chk("rst_spike_count", 64'(spike_count), 64'(0));
    chk("rst_cmp_b", 64'(cmp_b), 64'(0));
    rst = 1'b0;
    idle(2);

    // all below threshold
    do_pass(32'h3F80_0000, 32'h0000_0000, 1'b0);
    idle(3);

    // above and equal to threshold at 3 and 9
    fill_mem(32'h3E80_0000);
    set_mem(3, 32'h4000_0000);
    set_mem(9, 32'h3F80_0000);
    do_pass(32'h3F80_0000, 32'h0000_0000, 1'b0);
    chk("spike_vec_0208", 64'(spike_vec), 64'(16'h0208));
    chk("ram3_reset", 64'(ram[3]), 64'(exp_mem[3]));
    chk("ram9_reset", 64'(ram[9]), 64'(exp_mem[9]));
    chk("ram4_kept", 64'(ram[4]), 64'(exp_mem[4]));
    idle(3);

    // negative potentials, equality at index 2
    fill_mem(32'hC120_0000);
    set_mem(0, 32'hC040_0000);
    set_mem(1, 32'hC0A0_0000);
    set_mem(2, 32'hC080_0000);
    do_pass(32'hC080_0000, 32'h3F80_0000, 1'b0);
    idle(3);

    // start re-pulsed mid-pass and in DONE, threshold/v_reset changed mid-pass
    fill_mem(32'h3F00_0000);
    set_mem(7, 32'h3FC0_0000);
    do_pass(32'h3F80_0000, 32'h4040_0000, 1'b1);
    idle(3);
    chk("start_in_done_ignored", 64'(busy), 64'(0));

    // reset mid-pass: neurons 2 and 3 would fire, only 2 is written before rst
    fill_mem(32'h3E80_0000);
    set_mem(2, 32'h4000_0000);
    set_mem(3, 32'h4000_0000);
    wq.push_back({4'd2, 32'h0000_0000});
    exp_mem[2] = 32'h0000_0000;
    @(negedge clk);
    threshold = 32'h3F80_0000;
    v_reset   = 32'h0000_0000;
    start     = 1'b1;
    rd_idx    = 0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("rstmid_busy", 64'(busy), 64'(1));
    end
    chk("rstmid_vec_before", 64'(spike_vec), 64'(16'h0004));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_busy_after", 64'(busy), 64'(0));
    chk("rstmid_vec_after", 64'(spike_vec), 64'(0));
    chk("rstmid_count_after", 64'(spike_count), 64'(0));
    chk("rstmid_rd_en_after", 64'(mem_rd_en), 64'(0));
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("rstmid_no_done", 64'(done), 64'(0));
      chk("rstmid_no_wr", 64'(mem_wr_en), 64'(0));
    end
    chk("rstmid_writes", 64'(wq.size()), 64'(0));
    chk("rstmid_ram3_kept", 64'(ram[3]), 64'(exp_mem[3]));

    // fresh pass: +0 against -0 threshold fires, last index fires
    fill_mem(32'hBF80_0000);
    set_mem(5, 32'h0000_0000);
    set_mem(15, 32'h4000_0000);
    do_pass(32'h8000_0000, 32'h3F00_0000, 1'b0);
    chk("spike_vec_8020", 64'(spike_vec), 64'(16'h8020));

    // back-to-back: start in the cycle right after done
    set_mem(0, 32'h4100_0000);
    do_pass(32'h3F80_0000, 32'h0000_0000, 1'b0);
    chk("spike_vec_0001", 64'(spike_vec), 64'(16'h0001));
    chk("ram0_reset", 64'(ram[0]), 64'(exp_mem[0]));
    idle(5);
    chk("hold_spike_vec", 64'(spike_vec), 64'(16'h0001));
    chk("hold_spike_count", 64'(spike_count), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_threshold_scheduler.md
Name: spike_threshold_scheduler

Overview:
- Sequences one shared floating-point comparator over NUM_NEURONS membrane potentials held in an external single-port potential RAM.
- Per neuron: reads the potential, compares it against a firing threshold, records a spike flag, and writes back the reset potential for neurons that fired.
- Sits between the neuron-update stage and the spike-propagation logic, and runs once per timestep when triggered by start.

Parameters:
- NUM_NEURONS, 16, number of neurons scanned per pass (>=2).
- ADDR_W, 4, potential-RAM address width; must satisfy 2**ADDR_W >= NUM_NEURONS.
- CNT_W, 5, spike_count width; must hold NUM_NEURONS.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a scan pass; sampled only in IDLE.
- threshold  in  32  IEEE-754 single firing threshold; latched on start acceptance.
- v_reset  in  32  IEEE-754 single post-spike potential; latched on start acceptance.
- mem_rd_en  out  1  RAM read strobe; data is returned one cycle later.
- mem_wr_en  out  1  RAM write strobe.
- mem_addr  out  ADDR_W  RAM address, shared by reads and writes.
- mem_wr_data  out  32  write data (latched v_reset).
- mem_rd_data  in  32  RAM read data, valid the cycle after mem_rd_en.
- cmp_a  out  32  comparator operand A (potential).
- cmp_b  out  32  comparator operand B (latched threshold).
- cmp_lt  in  1  comparator result = sign bit of (cmp_a - cmp_b); 1 means A < B. Combinational.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse at the end of a pass.
- spike_vec  out  NUM_NEURONS  bit i = neuron i fired in the last pass.
- spike_count  out  CNT_W  number of spikes in the last pass.

Behaviour:
- Reset: state=IDLE. busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, spike_vec, spike_count and the internal index all go to 0; threshold and v_reset latches go to 0.
- cmp_a = mem_rd_data and cmp_b = thr_q at all times (continuous assignment). cmp_lt is used only in CMP.
- FSM states:
  - IDLE: if start, latch threshold and v_reset, clear spike_vec and spike_count, set idx=0, go to READ. Otherwise stay.
  - READ: busy=1, mem_rd_en=1, mem_addr=idx, go to CMP.
  - CMP: mem_rd_data is valid. Register fire = ~cmp_lt, go to WB. No RAM strobes.
  - WB: if fire, then mem_wr_en=1, mem_addr=idx, mem_wr_data=v_reset latch, spike_vec[idx] set to 1, spike_count incremented.
    - If idx==NUM_NEURONS-1, go to DONE; otherwise idx+1, go to READ.
  - DONE: done=1 for exactly this cycle, busy=0, go to IDLE.
- Outputs mem_rd_en, mem_wr_en, mem_addr and mem_wr_data are registered and asserted only in their stated states; they are 0 elsewhere.
- Timing: 3 cycles per neuron. If start is sampled at edge 0, done is high during cycle 3*NUM_NEURONS+1 (cycle 49 for N=16). busy is high during cycles 1..3N.
- The same address is never read and written in the same cycle.
- Equality: potential == threshold gives a difference of +0, sign 0, so the neuron fires. +0 vs -0 also fires.
- NaN and infinity operands are not specially handled; the spike decision is the raw ~cmp_lt.
- start while busy or in DONE is ignored; there is no queuing.
- spike_vec and spike_count hold their values after done until the next accepted start.
- Changes to threshold or v_reset mid-pass have no effect.
- rst mid-pass: return to IDLE next cycle, issue no further reads or writes, clear spike_vec and spike_count, no done pulse.
- idx is never incremented past NUM_NEURONS-1.

Test Plan:
- RAM all 0.5 (0x3F000000), threshold 1.0 (0x3F800000), start -> no writes, spike_vec=0, spike_count=0, done at cycle 49.
- RAM[3]=2.0 and RAM[9]=1.0, others 0.25, threshold 1.0, v_reset 0.0 -> writes of 0x00000000 only at addresses 3 and 9, spike_vec=0x0208, spike_count=2; RAM[3]/RAM[9] read 0 afterwards.
- Negative values: RAM[0]=-3.0, threshold -4.0 -> neuron 0 fires. RAM[1]=-5.0 -> neuron 1 does not fire.
- start re-pulsed at cycles 5 and 20 of a pass, and threshold changed mid-pass -> single done at cycle 49, results follow the originally latched threshold.
- rst asserted at cycle 10 with neuron 2 firing pending -> busy=0 and spike_vec=0 next cycle, no write at address 3 or later, no done pulse; a fresh start afterwards completes normally.
- Back-to-back passes: start asserted in the cycle after done -> accepted, spike_vec cleared, second pass results are independent of the first.
